// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start detect, per-bit edge counting, LSB-first deserialization,
// parity/stop checking. Optional break detection is enabled with UART_RX_BREAK_DET_EN.
module uart_rx_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ECNT_W     = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_in,
    input  logic [5:0]            prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  sampled_bit,
    output logic                  dat_samp_en,
    output logic [ECNT_W-1:0]     edge_cnt,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  break_det
);

    localparam int unsigned BCNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [ECNT_W-1:0]     edge_q, edge_d;
    logic [BCNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic [5:0]            pre_q, pre_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  par_bad_q, par_bad_d;
    logic                  valid_q, valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;

    logic bit_end, last_bit, start_det, stop_end, arm_ok, is_break;

    assign bit_end   = (state_q != StIdle) && (32'(edge_q) == 32'(pre_q) - 32'd1);
    assign last_bit  = (bit_cnt_q == BCNT_W'(DATA_WIDTH - 1));
    assign start_det = (state_q == StIdle) && !rx_in && arm_ok;
    assign stop_end  = (state_q == StStop) && bit_end;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start_det) state_d = StStart;
            StStart:  if (bit_end) state_d = sampled_bit ? StIdle : StData;
            StData:   if (bit_end && last_bit) state_d = par_en_q ? StParity : StStop;
            StParity: if (bit_end) state_d = StStop;
            StStop:   if (bit_end) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Outputs decoded from the state register only
    always_comb begin
        dat_samp_en = (state_q != StIdle);
    end

    always_comb begin
        edge_d    = edge_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        p_data_d  = p_data_q;
        pre_d     = pre_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        par_bad_d = par_bad_q;
        valid_d   = 1'b0;
        par_err_d = 1'b0;
        stp_err_d = 1'b0;

        if (state_q == StIdle) begin
            // The detection cycle itself is edge 0 of the start bit.
            edge_d = start_det ? ECNT_W'(1) : '0;
        end else begin
            edge_d = bit_end ? '0 : edge_q + ECNT_W'(1);
        end

        if (start_det) begin
            pre_d     = prescale;
            par_en_d  = par_en;
            par_typ_d = par_typ;
            par_bad_d = 1'b0;
            bit_cnt_d = '0;
        end

        if ((state_q == StData) && bit_end) begin
            shift_d   = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
            bit_cnt_d = last_bit ? '0 : bit_cnt_q + BCNT_W'(1);
        end

        if ((state_q == StParity) && bit_end) begin
            par_bad_d = sampled_bit != (^shift_q ^ par_typ_q);
        end

        if (stop_end && !is_break) begin
            if (par_bad_q) begin
                par_err_d = 1'b1;
            end else if (!sampled_bit) begin
                stp_err_d = 1'b1;
            end else begin
                valid_d  = 1'b1;
                p_data_d = shift_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_q    <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            p_data_q  <= '0;
            pre_q     <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            par_bad_q <= 1'b0;
            valid_q   <= 1'b0;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
        end else begin
            edge_q    <= edge_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            p_data_q  <= p_data_d;
            pre_q     <= pre_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            par_bad_q <= par_bad_d;
            valid_q   <= valid_d;
            par_err_q <= par_err_d;
            stp_err_q <= stp_err_d;
        end
    end

`ifdef UART_RX_BREAK_DET_EN
    logic       par_bit_q, par_bit_d;
    logic       brk_wait_q, brk_wait_d;
    logic [5:0] hcnt_q, hcnt_d;
    logic       brk_q;

    assign is_break  = (shift_q == '0) && !sampled_bit && !(par_en_q && par_bit_q);
    assign arm_ok    = !brk_wait_q;
    assign break_det = brk_q;

    // After a break the line must idle high for a full bit time before re-arming.
    always_comb begin
        par_bit_d  = par_bit_q;
        brk_wait_d = brk_wait_q;
        hcnt_d     = hcnt_q;
        if (start_det) begin
            par_bit_d = 1'b0;
        end
        if ((state_q == StParity) && bit_end) begin
            par_bit_d = sampled_bit;
        end
        if (stop_end && is_break) begin
            brk_wait_d = 1'b1;
            hcnt_d     = '0;
        end else if (brk_wait_q) begin
            if (!rx_in) begin
                hcnt_d = '0;
            end else if (hcnt_q == pre_q - 6'd1) begin
                brk_wait_d = 1'b0;
                hcnt_d     = '0;
            end else begin
                hcnt_d = hcnt_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bit_q  <= 1'b0;
            brk_wait_q <= 1'b0;
            hcnt_q     <= '0;
            brk_q      <= 1'b0;
        end else begin
            par_bit_q  <= par_bit_d;
            brk_wait_q <= brk_wait_d;
            hcnt_q     <= hcnt_d;
            brk_q      <= stop_end && is_break;
        end
    end
`else
    assign is_break  = 1'b0;
    assign arm_ok    = 1'b1;
    assign break_det = 1'b0;
`endif

    assign edge_cnt   = edge_q;
    assign p_data     = p_data_q;
    assign data_valid = valid_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;

endmodule
